icache_sa: RTL and testbench
============================

// Module: icache_sa
// PURPOSE
//  Parametrised N-way set-associative instruction cache between IF stage and the AXI burst master.
//  Replaces the direct-mapped single-burst-size cache: configurable ways/sets/line size, per-set
//  round-robin replacement, whole-cache invalidate (fence.i), and clean abort of a refill on flush.
//  Hit returns a 32-bit instruction combinationally in the same cycle; a miss starts one line refill.
// PARAMETERS
//  ADDR_W      64   PC / burst address width
//  WAYS        2    associativity; power of 2, 1..8
//  SETS        32   sets; power of 2, >=2
//  LINE_BYTES  16   line size; power of 2, 16..64; beats = LINE_BYTES/8
// PORTS
//  cpu_clk_50M       in   1           clock, all state on rising edge
//  cpu_rst_n         in   1           async active-low reset
//  cpu_if_ena        in   1           fetch request valid this cycle
//  cpu_if_pc         in   ADDR_W      fetch address; bits [1:0] ignored
//  read_isdone       out  1           instruction valid (hit) this cycle
//  icache_data_read  out  32          instruction; 32'h0 when read_isdone=0
//  flush             in   1           pipeline flush; abandons in-flight refill
//  fence_i           in   1           invalidate all lines
//  axi_isused        out  1           refill in flight (REFILL or DRAIN)
//  if_burst_valid    out  1           burst request; held until last beat
//  if_burst_addr     out  ADDR_W      line-aligned miss address (low log2(LINE_BYTES) bits 0)
//  if_burst_len      out  8           beats-1
//  if_burst_size     out  2           fixed 2'b11 (8 bytes/beat)
//  if_burst_ready    in   1           one beat of if_burst_data valid this cycle
//  if_burst_data     in   64          beat data, ascending address order
// BEHAVIOUR
//  Reset: all valid bits 0, victim pointers 0, state IDLE, every output 0 (if_burst_size 2'b11,
//   if_burst_len beats-1 are constants). Data/tag arrays not reset.
//  Address split: offset=log2(LINE_BYTES), index=log2(SETS), tag=remaining upper bits.
//  Hit: cpu_if_ena & some way valid with matching tag -> read_isdone=1 same cycle, word selected
//   by pc[offset-1:2]. Hits are served in any state except for the set/way being refilled.
//  States: IDLE -> REFILL on cpu_if_ena & miss & !flush & !fence_i; latch line addr, set, victim.
//   REFILL -> IDLE after last beat when no abort; line written, valid set, tag written on that edge;
//    retried fetch hits the next cycle (miss latency = beats + 2 cycles minimum).
//   REFILL -> DRAIN on flush or fence_i before last beat; if on the last beat itself, line is discarded
//    and state goes straight to IDLE.
//   DRAIN: accept and discard remaining beats; -> IDLE after last beat. Burst never truncated.
//  Beat counter: log2(beats)-bit, increments per if_burst_ready, wraps to 0 on last beat; ready
//   outside REFILL/DRAIN ignored.
//  Victim: lowest-numbered invalid way in set; if all valid, per-set round-robin pointer, which
//   advances (mod WAYS) only on a committed refill.
//  fence_i: clears all valid bits on that edge; read_isdone forced 0 that cycle.
//  flush in IDLE: no effect besides suppressing a new refill that cycle.
//  Simultaneous fence_i and last beat: invalidate wins, line not validated.
// CONFIGURATION
//  ICACHE_PERF_CNT_EN defined: adds outputs hit_cnt[31:0], miss_cnt[31:0]; hit_cnt +1 per cycle with
//   read_isdone=1, miss_cnt +1 per IDLE->REFILL transition; both wrap, reset to 0.
//  Not defined: ports and counters absent; functional behaviour identical.
// TESTING
//  Cold fetch pc=0x8000_0000 -> if_burst_valid, addr 0x8000_0000, len 1; 2 beats; then hit, read_isdone=1.
//  Fetch 0x8000_0004 after fill -> hit, data = beat0[63:32], no burst.
//  WAYS=2: fill 0x8000_0000, 0x8000_0200, 0x8000_0400 (same set) -> third evicts way0; 0x8000_0200 still hits.
//  flush after beat0 of refill -> DRAIN, beat1 consumed, set stays invalid, re-fetch misses again.
//  fence_i after three fills -> all fetches miss; fence_i on last beat -> line not valid.
//  Reset asserted mid-REFILL -> all outputs 0 immediately, valid bits cleared, next fetch misses.

Source files
------------

// File: rtl/icache_sa.sv
// icache_sa: N-way set-associative instruction cache sitting between the IF
// stage and the AXI burst master. Hits return a 32-bit word combinationally;
// a miss fetches one whole line as a single burst.
// Optional build macro ICACHE_PERF_CNT_EN adds free-running hit/miss counters.
module icache_sa #(
  parameter int ADDR_W     = 64,
  parameter int WAYS       = 2,
  parameter int SETS       = 32,
  parameter int LINE_BYTES = 16
) (
  input  logic              cpu_clk_50M,
  input  logic              cpu_rst_n,
  input  logic              cpu_if_ena,
  input  logic [ADDR_W-1:0] cpu_if_pc,
  output logic              read_isdone,
  output logic [31:0]       icache_data_read,
  input  logic              flush,
  input  logic              fence_i,
  output logic              axi_isused,
  output logic              if_burst_valid,
  output logic [ADDR_W-1:0] if_burst_addr,
  output logic [7:0]        if_burst_len,
  output logic [1:0]        if_burst_size,
  input  logic              if_burst_ready,
  input  logic [63:0]       if_burst_data
`ifdef ICACHE_PERF_CNT_EN
  ,
  output logic [31:0]       hit_cnt,
  output logic [31:0]       miss_cnt
`endif
);

  localparam int BEATS  = LINE_BYTES / 8;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int OFF_W  = $clog2(LINE_BYTES);
  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = ADDR_W - OFF_W - IDX_W;
  localparam int WSEL_W = OFF_W - 2;
  localparam int WORDS  = LINE_BYTES / 4;
  localparam int LINE_W = LINE_BYTES * 8;
  localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REFILL = 2'd1,
    S_DRAIN  = 2'd2
  } state_t;

  state_t              state_q;
  logic [BEAT_W-1:0]   beat_q;
  logic [WAY_W-1:0]    rf_way_q;
  logic [ADDR_W-1:0]   rf_addr_q;
  logic                busy_q;

  logic [WAYS-1:0]     valid_q  [SETS];
  logic [WAY_W-1:0]    rr_q     [SETS];
  logic [LINE_W-1:0]   data_mem [WAYS][SETS];
  logic [TAG_W-1:0]    tag_mem  [WAYS][SETS];
  logic [LINE_W-1:0]   line_buf_q;
  logic [LINE_W-1:0]   fill_line;
  logic [LINE_W-1:0]   hit_line;

  logic [TAG_W-1:0]    pc_tag;
  logic [IDX_W-1:0]    pc_idx;
  logic [WSEL_W-1:0]   pc_wsel;
  logic [TAG_W-1:0]    rf_tag;
  logic [IDX_W-1:0]    rf_idx;
  logic                refilling;
  logic                hit_any;
  logic [WAY_W-1:0]    hit_way;
  logic                vic_found;
  logic [WAY_W-1:0]    vic_way;
  logic                start_refill;
  logic                last_beat;
  logic                abort;
  logic                commit;
  logic                unused_pc_lsb;

  assign pc_tag        = cpu_if_pc[ADDR_W-1 -: TAG_W];
  assign pc_idx        = cpu_if_pc[OFF_W +: IDX_W];
  assign pc_wsel       = cpu_if_pc[2 +: WSEL_W];
  assign unused_pc_lsb = ^cpu_if_pc[1:0];
  assign rf_tag        = rf_addr_q[ADDR_W-1 -: TAG_W];
  assign rf_idx        = rf_addr_q[OFF_W +: IDX_W];
  assign refilling     = (state_q == S_REFILL);

  assign if_burst_len   = 8'(BEATS - 1);
  assign if_burst_size  = 2'b11;
  assign if_burst_addr  = rf_addr_q;
  assign if_burst_valid = busy_q;
  assign axi_isused     = busy_q;

  // Tag compare across all ways; the way currently being refilled is masked.
  always_comb begin
    hit_any = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[pc_idx][w] && (tag_mem[w][pc_idx] == pc_tag) &&
          !(refilling && (rf_idx == pc_idx) && (rf_way_q == WAY_W'(w)))) begin
        hit_any = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  assign read_isdone = cpu_if_ena & ~fence_i & hit_any;

  // Select the addressed 32-bit word of the hitting line; zero on no hit.
  always_comb begin
    hit_line         = data_mem[hit_way][pc_idx];
    icache_data_read = '0;
    if (read_isdone) begin
      for (int i = 0; i < WORDS; i++) begin
        if (pc_wsel == WSEL_W'(i)) icache_data_read = hit_line[i*32 +: 32];
      end
    end
  end

  // Victim: first invalid way, otherwise the set's round-robin pointer.
  always_comb begin
    vic_found = 1'b0;
    vic_way   = rr_q[pc_idx];
    for (int w = 0; w < WAYS; w++) begin
      if (!vic_found && !valid_q[pc_idx][w]) begin
        vic_found = 1'b1;
        vic_way   = WAY_W'(w);
      end
    end
  end

  assign start_refill = (state_q == S_IDLE) & cpu_if_ena & ~hit_any & ~flush & ~fence_i;
  assign last_beat    = (beat_q == BEAT_W'(BEATS - 1));
  assign abort        = flush | fence_i;
  assign commit       = refilling & if_burst_ready & last_beat & ~abort;

  // Merge the incoming beat into the assembly buffer at the current beat slot.
  always_comb begin
    fill_line = line_buf_q;
    for (int b = 0; b < BEATS; b++) begin
      if (beat_q == BEAT_W'(b)) fill_line[b*64 +: 64] = if_burst_data;
    end
  end

  // Line assembly and array writes; data and tags carry no reset.
  always_ff @(posedge cpu_clk_50M) begin
    if (refilling && if_burst_ready) line_buf_q <= fill_line;
    if (commit) begin
      data_mem[rf_way_q][rf_idx] <= fill_line;
      tag_mem[rf_way_q][rf_idx]  <= rf_tag;
    end
  end

  // Refill FSM: IDLE -> REFILL on miss, DRAIN on abort, back to IDLE after last beat.
  always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      state_q   <= S_IDLE;
      beat_q    <= '0;
      rf_way_q  <= '0;
      rf_addr_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_refill) begin
            state_q   <= S_REFILL;
            busy_q    <= 1'b1;
            beat_q    <= '0;
            rf_way_q  <= vic_way;
            rf_addr_q <= {cpu_if_pc[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
          end
        end
        S_REFILL: begin
          if (if_burst_ready) beat_q <= last_beat ? '0 : beat_q + BEAT_W'(1);
          if (if_burst_ready && last_beat) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else if (abort) begin
            state_q <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (if_burst_ready) begin
            beat_q <= last_beat ? '0 : beat_q + BEAT_W'(1);
            if (last_beat) begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Valid bits and replacement pointers; fence_i invalidation has priority.
  always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        rr_q[s]    <= '0;
      end
    end else begin
      if (fence_i) begin
        for (int s = 0; s < SETS; s++) valid_q[s] <= '0;
      end else if (commit) begin
        valid_q[rf_idx][rf_way_q] <= 1'b1;
      end
      if (commit) rr_q[rf_idx] <= (WAYS == 1) ? '0 : rr_q[rf_idx] + WAY_W'(1);
    end
  end

`ifdef ICACHE_PERF_CNT_EN
  // Free-running hit/miss counters, wrapping at 2^32.
  always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if (read_isdone)  hit_cnt  <= hit_cnt + 32'd1;
      if (start_refill) miss_cnt <= miss_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_icache_sa.sv
// tb_icache_sa: directed bench for icache_sa (default parameters) with a
// line-level reference model of the cache contents and refill progress.
module tb_icache_sa;

  localparam int ADDR_W     = 64;
  localparam int WAYS       = 2;
  localparam int SETS       = 32;
  localparam int LINE_BYTES = 16;
  localparam int BEATS      = LINE_BYTES / 8;
  localparam int OFF        = 4;
  localparam int IDXB       = 5;

  logic              clk;
  logic              rst_n;
  logic              ena;
  logic [ADDR_W-1:0] pc;
  logic              read_isdone;
  logic [31:0]       icache_data_read;
  logic              flush;
  logic              fence_i;
  logic              axi_isused;
  logic              if_burst_valid;
  logic [ADDR_W-1:0] if_burst_addr;
  logic [7:0]        if_burst_len;
  logic [1:0]        if_burst_size;
  logic              ready;
  logic [63:0]       bdat;
`ifdef ICACHE_PERF_CNT_EN
  logic [31:0]       hit_cnt;
  logic [31:0]       miss_cnt;
`endif

  icache_sa #(
    .ADDR_W(ADDR_W), .WAYS(WAYS), .SETS(SETS), .LINE_BYTES(LINE_BYTES)
  ) dut (
    .cpu_clk_50M(clk),
    .cpu_rst_n(rst_n),
    .cpu_if_ena(ena),
    .cpu_if_pc(pc),
    .read_isdone(read_isdone),
    .icache_data_read(icache_data_read),
    .flush(flush),
    .fence_i(fence_i),
    .axi_isused(axi_isused),
    .if_burst_valid(if_burst_valid),
    .if_burst_addr(if_burst_addr),
    .if_burst_len(if_burst_len),
    .if_burst_size(if_burst_size),
    .if_burst_ready(ready),
    .if_burst_data(bdat)
`ifdef ICACHE_PERF_CNT_EN
    ,
    .hit_cnt(hit_cnt),
    .miss_cnt(miss_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit check_en = 1'b0;

  // Reference model: which line sits in which way, plus the in-flight refill.
  bit          m_valid [SETS][WAYS];
  logic [63:0] m_tag   [SETS][WAYS];
  int          m_ep    [SETS][WAYS];
  int          m_rr    [SETS];
  bit          m_busy, m_drain;
  logic [63:0] m_line;
  int          m_set, m_way, m_beats, m_cur_ep;
  int          m_serial = 0;
  int          m_hits, m_misses;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Instruction word the bench supplies for byte address a in refill number ep.
  function automatic logic [31:0] wordf(input logic [63:0] a, input int ep);
    logic [31:0] e;
    e = ep;
    return a[31:0] ^ {e[7:0], 24'h0} ^ 32'hC0DE_0000;
  endfunction

  function automatic int sidx(input logic [63:0] a);
    return int'((a >> OFF) % SETS);
  endfunction

  function automatic logic [63:0] stag(input logic [63:0] a);
    return a >> (OFF + IDXB);
  endfunction

  function automatic bit model_hit(input logic e, input logic [63:0] a, input logic f,
                                   output int way);
    int s;
    bit h;
    s = sidx(a);
    h = 1'b0;
    way = 0;
    if (e && !f) begin
      for (int w = 0; w < WAYS; w++) begin
        if (m_valid[s][w] && m_tag[s][w] == stag(a) &&
            !(m_busy && !m_drain && s == m_set && w == m_way)) begin
          h = 1'b1;
          way = w;
        end
      end
    end
    return h;
  endfunction

  function automatic bit tag_present(input logic [63:0] a);
    int s;
    s = sidx(a);
    for (int w = 0; w < WAYS; w++) if (m_valid[s][w] && m_tag[s][w] == stag(a)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int victim(input int s);
    for (int w = 0; w < WAYS; w++) if (!m_valid[s][w]) return w;
    return m_rr[s];
  endfunction

  task automatic model_reset();
    for (int s = 0; s < SETS; s++) begin
      m_rr[s] = 0;
      for (int w = 0; w < WAYS; w++) m_valid[s][w] = 1'b0;
    end
    m_busy = 1'b0; m_drain = 1'b0; m_beats = 0;
    m_hits = 0; m_misses = 0;
  endtask

  // Advance the model by one clock edge using the inputs presented this cycle.
  task automatic model_step();
    int hw;
    if (model_hit(ena, pc, fence_i, hw)) m_hits++;
    if (!m_busy) begin
      if (ena && !tag_present(pc) && !flush && !fence_i) begin
        m_line   = pc & ~64'(LINE_BYTES - 1);
        m_set    = sidx(pc);
        m_way    = victim(m_set);
        m_busy   = 1'b1;
        m_drain  = 1'b0;
        m_beats  = 0;
        m_cur_ep = m_serial;
        m_serial++;
        m_misses++;
      end
    end else if (ready) begin
      m_beats++;
      if (m_beats == BEATS) begin
        m_busy = 1'b0;
        if (!m_drain && !flush && !fence_i) begin
          m_valid[m_set][m_way] = 1'b1;
          m_tag[m_set][m_way]   = stag(m_line);
          m_ep[m_set][m_way]    = m_cur_ep;
          m_rr[m_set]           = (m_rr[m_set] + 1) % WAYS;
        end
      end else if (flush || fence_i) begin
        m_drain = 1'b1;
      end
    end else if (flush || fence_i) begin
      m_drain = 1'b1;
    end
    if (fence_i) begin
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < WAYS; w++) m_valid[s][w] = 1'b0;
    end
  endtask

  // Per-cycle comparison of every DUT output against the model.
  always @(negedge clk) begin
    if (check_en) begin
      int hw;
      bit eh;
      eh = model_hit(ena, pc, fence_i, hw);
      check("read_isdone", 64'(read_isdone), 64'(eh));
      check("icache_data_read", 64'(icache_data_read),
            eh ? 64'(wordf(pc & ~64'h3, m_ep[sidx(pc)][hw])) : 64'h0);
      check("axi_isused", 64'(axi_isused), 64'(m_busy));
      check("if_burst_valid", 64'(if_burst_valid), 64'(m_busy));
      if (m_busy) check("if_burst_addr", if_burst_addr, m_line);
      check("if_burst_len", 64'(if_burst_len), 64'(BEATS - 1));
      check("if_burst_size", 64'(if_burst_size), 64'h3);
`ifdef ICACHE_PERF_CNT_EN
      check("hit_cnt", 64'(hit_cnt), 64'(m_hits));
      check("miss_cnt", 64'(miss_cnt), 64'(m_misses));
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic fetch(input logic [63:0] a, input logic fl, input logic fe,
                       output logic h, output logic [31:0] d);
    ena = 1'b1; pc = a; flush = fl; fence_i = fe;
    #3;
    h = read_isdone;
    d = icache_data_read;
    tick();
    ena = 1'b0; flush = 1'b0; fence_i = 1'b0;
  endtask

  task automatic beat(input logic fl, input logic fe);
    logic [63:0] a;
    a = m_line + 64'(8 * m_beats);
    ready = 1'b1;
    bdat  = {wordf(a + 64'd4, m_cur_ep), wordf(a, m_cur_ep)};
    flush = fl; fence_i = fe;
    tick();
    ready = 1'b0; bdat = '0; flush = 1'b0; fence_i = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (!axi_isused) break;
      tick();
    end
    check("refill_done_in_budget", 64'(axi_isused), 64'h0);
  endtask

  task automatic serve();
    for (int b = 0; b < BEATS; b++) beat(1'b0, 1'b0);
    wait_idle(8);
  endtask

  task automatic fill(input logic [63:0] a);
    logic h;
    logic [31:0] d;
    fetch(a, 1'b0, 1'b0, h, d);
    serve();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic h;
    logic [31:0] d;
    rst_n = 1'b0; ena = 1'b1; pc = 64'h8000_0000; flush = 1'b0; fence_i = 1'b0;
    ready = 1'b0; bdat = '0;
    model_reset();
    #2;
    check("rst_read_isdone", 64'(read_isdone), 64'h0);
    check("rst_data", 64'(icache_data_read), 64'h0);
    check("rst_axi_isused", 64'(axi_isused), 64'h0);
    check("rst_burst_valid", 64'(if_burst_valid), 64'h0);
    check("rst_burst_addr", if_burst_addr, 64'h0);
    check("rst_burst_len", 64'(if_burst_len), 64'h1);
    check("rst_burst_size", 64'(if_burst_size), 64'h3);
    ena = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check_en = 1'b1;

    // Cold miss, burst request, then hits on the filled line.
    fetch(64'h8000_0000, 1'b0, 1'b0, h, d);
    check("cold_miss", 64'(h), 64'h0);
    check("cold_burst_valid", 64'(if_burst_valid), 64'h1);
    check("cold_burst_addr", if_burst_addr, 64'h8000_0000);
    check("cold_burst_len", 64'(if_burst_len), 64'h1);
    serve();
    fetch(64'h8000_0000, 1'b0, 1'b0, h, d);
    check("hit_w0", 64'(h), 64'h1);
    check("hit_w0_data", 64'(d), 64'h40DE_0000);
    fetch(64'h8000_0004, 1'b0, 1'b0, h, d);
    check("hit_w1_data", 64'(d), 64'h40DE_0004);
    check("hit_no_burst", 64'(axi_isused), 64'h0);
    fetch(64'h8000_000C, 1'b0, 1'b0, h, d);
    check("hit_w3_data", 64'(d), 64'h40DE_000C);

    // Three lines in set 0: third evicts way 0.
    fill(64'h8000_0200);
    fill(64'h8000_0400);
    fetch(64'h8000_0200, 1'b0, 1'b0, h, d);
    check("keep_0200", 64'(h), 64'h1);
    check("keep_0200_data", 64'(d), 64'h41DE_0200);
    fetch(64'h8000_0400, 1'b0, 1'b0, h, d);
    check("new_0400_data", 64'(d), 64'h42DE_0400);
    fetch(64'h8000_0000, 1'b0, 1'b0, h, d);
    check("evicted_0000", 64'(h), 64'h0);
    serve();

    // Flush in IDLE suppresses the refill; flush mid-refill drains.
    fetch(64'h8000_0100, 1'b1, 1'b0, h, d);
    check("flush_idle_no_refill", 64'(axi_isused), 64'h0);
    fetch(64'h8000_0010, 1'b0, 1'b0, h, d);
    beat(1'b0, 1'b0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("drain_busy", 64'(axi_isused), 64'h1);
    beat(1'b0, 1'b0);
    wait_idle(8);
    fetch(64'h8000_0010, 1'b0, 1'b0, h, d);
    check("refetch_after_drain", 64'(h), 64'h0);
    serve();

    // fence_i invalidates everything and blocks the hit in its own cycle.
    fetch(64'h8000_0004, 1'b0, 1'b1, h, d);
    check("fence_blocks_hit", 64'(h), 64'h0);
    fetch(64'h8000_0400, 1'b0, 1'b0, h, d);
    check("miss_after_fence", 64'(h), 64'h0);
    serve();
    fetch(64'h8000_0010, 1'b0, 1'b0, h, d);
    check("miss_after_fence_s1", 64'(h), 64'h0);
    serve();

    // Hit under refill of another set, then fence_i on the last beat.
    fetch(64'h8000_0050, 1'b0, 1'b0, h, d);
    beat(1'b0, 1'b0);
    fetch(64'h8000_0400, 1'b0, 1'b0, h, d);
    check("hit_under_refill", 64'(h), 64'h1);
    beat(1'b0, 1'b1);
    check("fence_last_idle", 64'(axi_isused), 64'h0);
    fetch(64'h8000_0050, 1'b0, 1'b0, h, d);
    check("fence_last_not_valid", 64'(h), 64'h0);
    serve();

    // Asynchronous reset in the middle of a refill.
    fetch(64'h8000_0060, 1'b0, 1'b0, h, d);
    beat(1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    check_en = 1'b0;
    model_reset();
    #1;
    check("mid_rst_axi_isused", 64'(axi_isused), 64'h0);
    check("mid_rst_burst_valid", 64'(if_burst_valid), 64'h0);
    check("mid_rst_burst_addr", if_burst_addr, 64'h0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    check_en = 1'b1;
    fetch(64'h8000_0050, 1'b0, 1'b0, h, d);
    check("miss_after_reset", 64'(h), 64'h0);
    serve();
    fetch(64'h8000_0050, 1'b0, 1'b0, h, d);
    check("hit_after_reset_fill", 64'(h), 64'h1);

    check_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
